// File: rtl/firc_out_pkg.sv
// firc_out_pkg: shared sample type, drop-counter ceiling and pointer-width helper
package firc_out_pkg;
  typedef struct packed {
    logic signed [31:0] I;
    logic signed [31:0] Q;
  } OutSamp;
  localparam int DROP_MAX = 255;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/firc_out_mem.sv
// firc_out_mem: DEPTH x 64-bit register array, one write port, asynchronous read
module firc_out_mem
  import firc_out_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  OutSamp        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output OutSamp        o_rdata
);
  OutSamp r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/firc_out_stage.sv
// firc_out_stage: FWFT output FIFO behind the complex FIR with throttle hint and drop logging
module firc_out_stage
  import firc_out_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    PushIn,
  input  logic [31:0]             FIIn,
  input  logic [31:0]             FQIn,
  output logic                    AlmostFull,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [31:0]             OutI,
  output logic [31:0]             OutQ,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Overflow,
  output logic [7:0]              DropCnt,
  input  logic                    ClrOverflow
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic [7:0]    r_drop;
  logic          w_pop, w_full, w_push, w_drop, w_we;
  OutSamp        w_wr, w_rd;
  assign w_pop  = (r_cnt != '0) && OutReady;
  assign w_full = r_cnt == CW'(DEPTH);
  assign w_push = PushIn && (!w_full || w_pop);
  assign w_drop = PushIn && w_full && !w_pop;
  assign w_we   = w_push && Reset_n;
  assign w_wr   = {FIIn, FQIn};
  firc_out_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wp),
    .i_wdata (w_wr),
    .i_raddr (r_rp),
    .o_rdata (w_rd)
  );
  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk)
    if (!Reset_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_wp   <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp   <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf  <= ClrOverflow ? 1'b0 : (r_ovf || w_drop);
      r_drop <= ClrOverflow ? '0 :
                (w_drop && r_drop != 8'(DROP_MAX)) ? r_drop + 8'd1 : r_drop;
    end
  assign OutValid   = r_cnt != '0;
  assign OutI       = w_rd.I;
  assign OutQ       = w_rd.Q;
  assign Count      = r_cnt;
  assign AlmostFull = (DEPTH - int'(r_cnt)) <= AF_MARGIN;
  assign Overflow   = r_ovf;
  assign DropCnt    = r_drop;
endmodule

// File: tb/tb_firc_out_stage.sv
// tb_firc_out_stage: scoreboard bench for the FIR output FIFO
module tb_firc_out_stage;
  logic        clk = 0;
  logic        Reset_n, PushIn, OutReady, ClrOverflow;
  logic [31:0] FIIn, FQIn;
  logic        AlmostFull, OutValid, Overflow;
  logic [31:0] OutI, OutQ;
  logic [3:0]  Count;
  logic [7:0]  DropCnt;
  int checks = 0, failures = 0, n_rx = 0;
  int m_cnt = 0, m_drop = 0;
  logic m_ovf = 0;
  logic [63:0] q_exp[$];

  firc_out_stage #(.DEPTH(8), .AF_MARGIN(2)) dut (
    .clk(clk), .Reset_n(Reset_n), .PushIn(PushIn), .FIIn(FIIn), .FQIn(FQIn),
    .AlmostFull(AlmostFull), .OutValid(OutValid), .OutReady(OutReady),
    .OutI(OutI), .OutQ(OutQ), .Count(Count), .Overflow(Overflow),
    .DropCnt(DropCnt), .ClrOverflow(ClrOverflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // consumer side of the scoreboard: every handshake pops and compares the oldest expected pair
  always @(negedge clk) begin
    if (Reset_n && OutValid && OutReady) begin
      checks++;
      if (q_exp.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got I=%h Q=%h expected no entry", OutI, OutQ);
      end else begin
        logic [63:0] e;
        e = q_exp.pop_front();
        n_rx++;
        if ({OutI, OutQ} !== e) begin
          failures++;
          $display("FAIL pop_data got I=%h Q=%h expected I=%h Q=%h", OutI, OutQ, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic push, input logic [31:0] i, input logic [31:0] q,
                       input logic rdy, input logic clr);
    logic pop, acc;
    pop = (m_cnt != 0) && rdy;
    acc = push && (m_cnt < 8 || pop);
    if (acc) q_exp.push_back({i, q});
    if (clr) begin
      m_ovf = 0;
      m_drop = 0;
    end else if (push && !acc) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    m_cnt = m_cnt + int'(acc) - int'(pop);
    PushIn = push; FIIn = i; FQIn = q; OutReady = rdy; ClrOverflow = clr;
    @(posedge clk); #1;
    PushIn = 0; OutReady = 0; ClrOverflow = 0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset;
    Reset_n = 0; PushIn = 0; OutReady = 0; ClrOverflow = 0; FIIn = 0; FQIn = 0;
    repeat (2) @(posedge clk);
    #1 Reset_n = 1;
    checks += 5;
    if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", OutValid); end
    if (Count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d expected 0", Count); end
    if (AlmostFull !== 1'b0) begin failures++; $display("FAIL reset_af got %b expected 0", AlmostFull); end
    if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b expected 0", Overflow); end
    if (DropCnt !== 8'd0) begin failures++; $display("FAIL reset_drop got %0d expected 0", DropCnt); end
  endtask

  task automatic test_single;
    drive(1, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0);
    checks += 4;
    if (OutValid !== 1'b1) begin failures++; $display("FAIL single_valid got %b expected 1", OutValid); end
    if (OutI !== 32'h1) begin failures++; $display("FAIL single_I got %h expected 00000001", OutI); end
    if (OutQ !== 32'hFFFF_FFFF) begin failures++; $display("FAIL single_Q got %h expected ffffffff", OutQ); end
    if (Count !== 4'd1) begin failures++; $display("FAIL single_count got %0d expected 1", Count); end
    drain(1);
    checks += 2;
    if (OutValid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got %b expected 0", OutValid); end
    if (Count !== 4'd0) begin failures++; $display("FAIL single_pop_count got %0d expected 0", Count); end
    drive(1, 32'h0BAD_CAFE, 32'h1234_5678, 1, 0);
    checks += 2;
    if (OutValid !== 1'b1) begin failures++; $display("FAIL nobypass_valid got %b expected 1", OutValid); end
    if (Count !== 4'd1) begin failures++; $display("FAIL nobypass_count got %0d expected 1", Count); end
    drain(1);
    checks++;
    if (q_exp.size() != 0) begin failures++; $display("FAIL single_left got %0d expected 0", q_exp.size()); end
  endtask

  task automatic test_fill_overflow;
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'(k), ~32'(k), 0, 0);
      checks += 2;
      if (Count !== 4'(m_cnt)) begin failures++; $display("FAIL fill_count[%0d] got %0d expected %0d", k, Count, m_cnt); end
      if (AlmostFull !== (m_cnt >= 6)) begin failures++; $display("FAIL fill_af[%0d] got %b expected %b", k, AlmostFull, m_cnt >= 6); end
    end
    checks += 3;
    if (Count !== 4'd8) begin failures++; $display("FAIL fill_final_count got %0d expected 8", Count); end
    if (Overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got %b expected 1", Overflow); end
    if (DropCnt !== 8'd2) begin failures++; $display("FAIL fill_drop got %0d expected 2", DropCnt); end
    drain(8);
    checks += 2;
    if (q_exp.size() != 0) begin failures++; $display("FAIL fill_left got %0d expected 0", q_exp.size()); end
    if (OutValid !== 1'b0) begin failures++; $display("FAIL fill_drained_valid got %b expected 0", OutValid); end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_full_pushpop;
    for (int k = 0; k < 8; k++) drive(1, 32'(k), 32'(k) << 4, 0, 0);
    drive(1, 32'd8, 32'd8 << 4, 1, 0);
    checks += 3;
    if (Count !== 4'd8) begin failures++; $display("FAIL fullpp_count got %0d expected 8", Count); end
    if (Overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got %b expected 0", Overflow); end
    if (DropCnt !== 8'd0) begin failures++; $display("FAIL fullpp_drop got %0d expected 0", DropCnt); end
    drain(8);
    checks++;
    if (q_exp.size() != 0) begin failures++; $display("FAIL fullpp_left got %0d expected 0", q_exp.size()); end
  endtask

  task automatic test_wrap;
    int sent = 0, rx0 = n_rx;
    for (int c = 0; c < 200 && (sent < 20 || m_cnt != 0); c++) begin
      logic p;
      p = sent < 20 && m_cnt < 4;
      drive(p, 32'h100 + 32'(sent), 32'h8000_0000 | 32'(sent), c[0], 0);
      if (p) sent++;
    end
    checks += 3;
    if (n_rx - rx0 != 20) begin failures++; $display("FAIL wrap_rx got %0d expected 20", n_rx - rx0); end
    if (Overflow !== 1'b0) begin failures++; $display("FAIL wrap_ovf got %b expected 0", Overflow); end
    if (OutValid !== 1'b0) begin failures++; $display("FAIL wrap_valid got %b expected 0", OutValid); end
  endtask

  task automatic test_clear_sat;
    for (int k = 0; k < 8; k++) drive(1, 32'h200 + 32'(k), 32'(k), 0, 0);
    for (int k = 0; k < 300; k++) drive(1, 32'hDEAD_0000, 32'(k), 0, 0);
    checks += 2;
    if (DropCnt !== 8'd255) begin failures++; $display("FAIL sat_drop got %0d expected 255", DropCnt); end
    if (Overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf got %b expected 1", Overflow); end
    drive(1, 32'hDEAD_BEEF, 0, 0, 0);
    checks++;
    if (DropCnt !== 8'd255) begin failures++; $display("FAIL sat_hold got %0d expected 255", DropCnt); end
    drive(1, 32'hDEAD_BEEF, 1, 0, 1);
    checks += 3;
    if (Overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf got %b expected 0", Overflow); end
    if (DropCnt !== 8'd0) begin failures++; $display("FAIL clr_drop got %0d expected 0", DropCnt); end
    if (Count !== 4'd8) begin failures++; $display("FAIL clr_count got %0d expected 8", Count); end
    drain(8);
    checks++;
    if (q_exp.size() != 0) begin failures++; $display("FAIL sat_left got %0d expected 0", q_exp.size()); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 5; k++) drive(1, 32'h300 + 32'(k), 32'(k), 0, 0);
    checks++;
    if (Count !== 4'd5) begin failures++; $display("FAIL rmid_pre_count got %0d expected 5", Count); end
    Reset_n = 0; PushIn = 1; FIIn = 32'hBAD0_BAD0; FQIn = 32'hBAD1_BAD1; OutReady = 1;
    @(posedge clk); #1;
    Reset_n = 1; PushIn = 0; OutReady = 0;
    q_exp.delete(); m_cnt = 0; m_ovf = 0; m_drop = 0;
    checks += 5;
    if (Count !== 4'd0) begin failures++; $display("FAIL rmid_count got %0d expected 0", Count); end
    if (OutValid !== 1'b0) begin failures++; $display("FAIL rmid_valid got %b expected 0", OutValid); end
    if (AlmostFull !== 1'b0) begin failures++; $display("FAIL rmid_af got %b expected 0", AlmostFull); end
    if (Overflow !== 1'b0) begin failures++; $display("FAIL rmid_ovf got %b expected 0", Overflow); end
    if (DropCnt !== 8'd0) begin failures++; $display("FAIL rmid_drop got %0d expected 0", DropCnt); end
    drive(1, 32'h0000_0ABC, 32'h0000_0DEF, 0, 0);
    checks += 2;
    if (OutI !== 32'h0000_0ABC) begin failures++; $display("FAIL rmid_first_I got %h expected 00000abc", OutI); end
    if (Count !== 4'd1) begin failures++; $display("FAIL rmid_first_count got %0d expected 1", Count); end
    drain(1);
    checks++;
    if (q_exp.size() != 0) begin failures++; $display("FAIL rmid_left got %0d expected 0", q_exp.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_overflow;
    test_full_pushpop;
    test_wrap;
    test_clear_sat;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
